// File: rtl/network_run_if.sv
// network_run_if: command, network-step, clear and completion signals
// exchanged between the dispatcher/network/sink side (master) and the
// run controller (slave).
// Optional feature macro: NET_RUN_ABORT_EN adds the abort input.
interface network_run_if #(
    parameter int RUN_WIDTH = 16
);
    // Command channel from the dispatcher
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [RUN_WIDTH-1:0] cmd_arg;

    // Network stepping and sink monitoring
    logic                 net_step;
    logic                 net_valid;
    logic                 net_ready;
    logic                 clr;

    // Completion token
    logic                 done_valid;
    logic                 done_ready;
    logic [RUN_WIDTH-1:0] done_steps;

`ifdef NET_RUN_ABORT_EN
    logic                 abort;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, net_valid, net_ready, done_ready, abort,
        input  cmd_ready, net_step, clr, done_valid, done_steps
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, net_valid, net_ready, done_ready, abort,
        output cmd_ready, net_step, clr, done_valid, done_steps
    );
`else
    modport master (
        output cmd_valid, cmd_op, cmd_arg, net_valid, net_ready, done_ready,
        input  cmd_ready, net_step, clr, done_valid, done_steps
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, net_valid, net_ready, done_ready,
        output cmd_ready, net_step, clr, done_valid, done_steps
    );
`endif
endinterface

// File: rtl/network_run_ctrl.sv
// network_run_ctrl: sequences network execution in front of the output sink.
// Accepts RUN/CLR/SYNC commands, advances the network one timestep at a time
// (never issuing a step until the sink has captured the previous output),
// pulses clr for clears and returns a completion token with the step count.
// Optional feature macro: NET_RUN_ABORT_EN enables the abort input, which ends
// a RUN early while still letting an in-flight step be captured.
// All outputs are registered; cmd_ready is high exactly when the FSM is IDLE.
module network_run_ctrl #(
    parameter int RUN_WIDTH  = 16,
    parameter int CLR_CYCLES = 2
) (
    input  logic         clk,
    input  logic         arstn,
    network_run_if.slave bus
);

    // Clear counter must hold CLR_CYCLES itself
    localparam int CTR_W = $clog2(CLR_CYCLES + 1);

    localparam logic [RUN_WIDTH-1:0] RUN_ZERO = {RUN_WIDTH{1'b0}};
    localparam logic [RUN_WIDTH-1:0] RUN_ONE  = {{(RUN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CTR_W-1:0]     CTR_ZERO = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0]     CTR_ONE  = {{(CTR_W-1){1'b0}}, 1'b1};
    localparam logic [CTR_W-1:0]     CTR_LOAD = CTR_W'(CLR_CYCLES);

    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SYNC = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_STEP  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t               state_q,      state_d;
    logic [RUN_WIDTH-1:0] remaining_q,  remaining_d;
    logic [RUN_WIDTH-1:0] executed_q,   executed_d;
    logic [CTR_W-1:0]     clr_ctr_q,    clr_ctr_d;
    logic                 abort_pend_q, abort_pend_d;
    logic                 cmd_ready_q,  cmd_ready_d;
    logic                 net_step_q,   net_step_d;
    logic                 clr_q,        clr_d;
    logic                 done_valid_q, done_valid_d;
    logic [RUN_WIDTH-1:0] done_steps_q, done_steps_d;

    logic                 abort_s;
    logic                 cmd_fire_s;
    logic                 capture_s;

`ifdef NET_RUN_ABORT_EN
    assign abort_s = bus.abort;
`else
    // Without the abort feature a RUN always executes all of its steps
    assign abort_s = 1'b0;
`endif

    assign cmd_fire_s = bus.cmd_valid & cmd_ready_q;
    // The sink takes the network output only when both sides agree
    assign capture_s  = bus.net_valid & bus.net_ready;

    // Next-state and next-output computation for the run sequencer
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        executed_d   = executed_q;
        clr_ctr_d    = clr_ctr_q;
        abort_pend_d = abort_pend_q;
        net_step_d   = 1'b0;
        clr_d        = 1'b0;
        done_valid_d = done_valid_q;
        done_steps_d = done_steps_q;

        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (cmd_fire_s) begin
                    case (bus.cmd_op)
                        OP_RUN: begin
                            if (bus.cmd_arg != RUN_ZERO) begin
                                remaining_d = bus.cmd_arg;
                                executed_d  = RUN_ZERO;
                                state_d     = ST_STEP;
                            end else begin
                                // Empty run still owes the dispatcher a token
                                done_valid_d = 1'b1;
                                done_steps_d = RUN_ZERO;
                                state_d      = ST_DONE;
                            end
                        end
                        OP_CLR: begin
                            clr_ctr_d = CTR_LOAD;
                            clr_d     = 1'b1;
                            state_d   = ST_CLEAR;
                        end
                        OP_SYNC: begin
                            done_valid_d = 1'b1;
                            done_steps_d = RUN_ZERO;
                            state_d      = ST_DONE;
                        end
                        default: begin
                            // Reserved opcode: consumed with no effect
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_STEP: begin
                if (abort_s) begin
                    // Abort before the step is issued: finish with what ran
                    done_valid_d = 1'b1;
                    done_steps_d = executed_q;
                    abort_pend_d = 1'b0;
                    state_d      = ST_DONE;
                end else if (bus.net_ready) begin
                    // Sink is drained, so the next output has somewhere to go
                    net_step_d  = 1'b1;
                    remaining_d = remaining_q - RUN_ONE;
                    executed_d  = executed_q + RUN_ONE;
                    state_d     = ST_WAIT;
                end else begin
                    state_d = ST_STEP;
                end
            end

            ST_WAIT: begin
                // An abort here cannot cancel the step already issued
                abort_pend_d = abort_pend_q | abort_s;
                if (capture_s) begin
                    if ((remaining_q == RUN_ZERO) || abort_pend_q || abort_s) begin
                        done_valid_d = 1'b1;
                        done_steps_d = executed_q;
                        abort_pend_d = 1'b0;
                        state_d      = ST_DONE;
                    end else begin
                        state_d = ST_STEP;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_CLEAR: begin
                // clr was raised on entry; keep it for the remaining cycles
                if (clr_ctr_q > CTR_ONE) begin
                    clr_ctr_d = clr_ctr_q - CTR_ONE;
                    clr_d     = 1'b1;
                    state_d   = ST_CLEAR;
                end else begin
                    clr_ctr_d = CTR_ZERO;
                    clr_d     = 1'b0;
                    state_d   = ST_IDLE;
                end
            end

            ST_DONE: begin
                if (bus.done_ready) begin
                    done_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    done_valid_d = 1'b1;
                    state_d      = ST_DONE;
                end
            end

            default: begin
                // Unreachable encoding: recover to a quiet IDLE
                state_d      = ST_IDLE;
                remaining_d  = RUN_ZERO;
                executed_d   = RUN_ZERO;
                clr_ctr_d    = CTR_ZERO;
                abort_pend_d = 1'b0;
                done_valid_d = 1'b0;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State, counters and registered outputs; reset drops any pending work
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q      <= ST_IDLE;
            remaining_q  <= RUN_ZERO;
            executed_q   <= RUN_ZERO;
            clr_ctr_q    <= CTR_ZERO;
            abort_pend_q <= 1'b0;
            cmd_ready_q  <= 1'b1;
            net_step_q   <= 1'b0;
            clr_q        <= 1'b0;
            done_valid_q <= 1'b0;
            done_steps_q <= RUN_ZERO;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            executed_q   <= executed_d;
            clr_ctr_q    <= clr_ctr_d;
            abort_pend_q <= abort_pend_d;
            cmd_ready_q  <= cmd_ready_d;
            net_step_q   <= net_step_d;
            clr_q        <= clr_d;
            done_valid_q <= done_valid_d;
            done_steps_q <= done_steps_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.net_step   = net_step_q;
    assign bus.clr        = clr_q;
    assign bus.done_valid = done_valid_q;
    assign bus.done_steps = done_steps_q;

endmodule

// File: tb/tb_network_run_ctrl.sv
// tb_network_run_ctrl: self-checking bench for network_run_ctrl.
// A small network/sink model answers each net_step with an output two
// half-cycles later; expected completion counts are queued per command and
// compared when the token appears. Abort scenarios run with NET_RUN_ABORT_EN.
`timescale 1ns/1ps
module tb_network_run_ctrl;

    localparam int RW   = 16;
    localparam int CLRC = 2;

    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SYNC = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    logic clk   = 1'b0;
    logic arstn = 1'b0;

    always #5 clk = ~clk;

    network_run_if #(.RUN_WIDTH(RW)) bus ();

    network_run_ctrl #(.RUN_WIDTH(RW), .CLR_CYCLES(CLRC)) dut (
        .clk   (clk),
        .arstn (arstn),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] exp_q[$];

    int   step_cnt    = 0;
    int   clr_cnt     = 0;
    int   clr_run     = 0;
    int   clr_max_run = 0;
    int   both_cnt    = 0;
    int   ncyc        = 0;
    int   last_step   = -1;
    int   min_gap     = 1000;
    int   cap_cnt     = 0;
    logic cap_at_edge = 1'b0;
    logic pend        = 1'b0;

    // Sink capture as seen by the DUT at each rising edge
    initial begin
        forever begin
            @(posedge clk);
            cap_at_edge = bus.net_valid && bus.net_ready;
            if (cap_at_edge) cap_cnt++;
        end
    end

    // Network model plus step/clear monitors, evaluated on the falling edge
    initial begin
        bus.net_valid = 1'b0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!arstn) begin
                bus.net_valid = 1'b0;
                pend = 1'b0;
            end else begin
                if (cap_at_edge) bus.net_valid = 1'b0;
                if (pend) begin
                    bus.net_valid = 1'b1;
                    pend = 1'b0;
                end
                if (bus.net_step) pend = 1'b1;
            end
            if (bus.net_step) begin
                step_cnt++;
                if (last_step >= 0 && (ncyc - last_step) < min_gap) min_gap = ncyc - last_step;
                last_step = ncyc;
            end
            if (bus.clr) begin
                clr_cnt++;
                clr_run++;
                if (clr_run > clr_max_run) clr_max_run = clr_run;
            end else begin
                clr_run = 0;
            end
            if (bus.net_step && bus.clr) both_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        step_cnt    = 0;
        clr_cnt     = 0;
        clr_max_run = 0;
        both_cnt    = 0;
        last_step   = -1;
        min_gap     = 1000;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [RW-1:0] arg, output bit ok);
        bit rdy;
        ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        for (int i = 0; i < 50; i++) begin
            rdy = bus.cmd_ready;
            cycle();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_arg   = '0;
    endtask

    task automatic wait_done(input int maxc, output bit got);
        got = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (bus.done_valid) begin
                got = 1'b1;
                break;
            end
            cycle();
        end
    endtask

    task automatic ack_done();
        bus.done_ready = 1'b1;
        cycle();
        bus.done_ready = 1'b0;
    endtask

    function automatic logic [RW-1:0] pop_exp();
        logic [RW-1:0] v;
        v = '1;
        if (exp_q.size() > 0) v = exp_q.pop_front();
        return v;
    endfunction

    task automatic test_reset();
        bit ok;
        bit seen;
        int t;
        arstn = 1'b0;
        repeat (3) cycle();
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b want 1", bus.cmd_ready); end
        checks++; if (bus.net_step !== 1'b0) begin errors++; $display("FAIL rst_net_step: got %b want 0", bus.net_step); end
        checks++; if (bus.clr !== 1'b0) begin errors++; $display("FAIL rst_clr: got %b want 0", bus.clr); end
        checks++; if (bus.done_valid !== 1'b0) begin errors++; $display("FAIL rst_done_valid: got %b want 0", bus.done_valid); end
        checks++; if (bus.done_steps !== 16'd0) begin errors++; $display("FAIL rst_done_steps: got %0d want 0", bus.done_steps); end
        arstn = 1'b1;
        cycle();
        // Interrupt a RUN 5 after two steps
        clear_mon();
        send_cmd(OP_RUN, 16'd5, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t1_accept: got %b want 1", ok); end
        t = 0;
        while (step_cnt < 2 && t < 100) begin cycle(); t++; end
        checks++; if (step_cnt !== 2) begin errors++; $display("FAIL t1_two_steps: got %0d want 2", step_cnt); end
        arstn = 1'b0;
        cycle();
        checks++; if ({bus.net_step, bus.clr, bus.done_valid} !== 3'b000 || bus.done_steps !== 16'd0)
            begin errors++; $display("FAIL t1_outputs_zero: got step=%b clr=%b dv=%b ds=%0d want 0", bus.net_step, bus.clr, bus.done_valid, bus.done_steps); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL t1_cmd_ready: got %b want 1", bus.cmd_ready); end
        arstn = 1'b1;
        seen = 1'b0;
        t = step_cnt;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (bus.done_valid || !bus.cmd_ready) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL t1_no_token: got activity=%b want 0", seen); end
        checks++; if (step_cnt !== t) begin errors++; $display("FAIL t1_no_more_steps: got %0d want %0d", step_cnt, t); end
    endtask

    task automatic test_run3();
        bit ok;
        bit got;
        bit bad;
        logic [RW-1:0] e;
        clear_mon();
        exp_q.push_back(16'd3);
        send_cmd(OP_RUN, 16'd3, ok);
        wait_done(200, got);
        e = pop_exp();
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL t2_token: got %b want 1", got); end
        checks++; if (bus.done_steps !== e) begin errors++; $display("FAIL t2_done_steps: got %0d want %0d", bus.done_steps, e); end
        checks++; if (step_cnt !== 3) begin errors++; $display("FAIL t2_pulses: got %0d want 3", step_cnt); end
        checks++; if (min_gap < 2) begin errors++; $display("FAIL t2_step_gap: got %0d want >=2", min_gap); end
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (bus.done_valid !== 1'b1 || bus.done_steps !== e) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL t2_token_hold: got unstable=%b want 0", bad); end
        ack_done();
        checks++; if (bus.done_valid !== 1'b0 || bus.cmd_ready !== 1'b1)
            begin errors++; $display("FAIL t2_after_ack: got dv=%b rdy=%b want dv=0 rdy=1", bus.done_valid, bus.cmd_ready); end
    endtask

    task automatic test_stall();
        bit ok;
        bit got;
        logic [RW-1:0] e;
        clear_mon();
        exp_q.push_back(16'd2);
        send_cmd(OP_RUN, 16'd2, ok);
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (bus.net_valid) break;
        end
        // Step 1 was just captured; hold the sink busy before step 2
        bus.net_ready = 1'b0;
        repeat (10) cycle();
        checks++; if (step_cnt !== 1) begin errors++; $display("FAIL t3_held: got %0d steps want 1", step_cnt); end
        bus.net_ready = 1'b1;
        wait_done(200, got);
        e = pop_exp();
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL t3_token: got %b want 1", got); end
        checks++; if (bus.done_steps !== e) begin errors++; $display("FAIL t3_done_steps: got %0d want %0d", bus.done_steps, e); end
        checks++; if (step_cnt !== 2) begin errors++; $display("FAIL t3_pulses: got %0d want 2", step_cnt); end
        ack_done();
    endtask

    task automatic test_clr_sync();
        bit ok;
        bit got;
        bit dv_seen;
        logic [RW-1:0] e;
        clear_mon();
        send_cmd(OP_CLR, 16'd7, ok);
        dv_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (bus.done_valid) dv_seen = 1'b1;
        end
        checks++; if (clr_cnt !== CLRC) begin errors++; $display("FAIL t4_clr_cycles: got %0d want %0d", clr_cnt, CLRC); end
        checks++; if (clr_max_run !== CLRC) begin errors++; $display("FAIL t4_clr_consecutive: got %0d want %0d", clr_max_run, CLRC); end
        checks++; if (step_cnt !== 0 || both_cnt !== 0) begin errors++; $display("FAIL t4_no_step: got %0d steps want 0", step_cnt); end
        checks++; if (dv_seen !== 1'b0) begin errors++; $display("FAIL t4_no_token: got %b want 0", dv_seen); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL t4_idle: got %b want 1", bus.cmd_ready); end
        exp_q.push_back(16'd0);
        send_cmd(OP_SYNC, 16'd9, ok);
        wait_done(50, got);
        e = pop_exp();
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL t4_sync_token: got %b want 1", got); end
        checks++; if (bus.done_steps !== e) begin errors++; $display("FAIL t4_sync_steps: got %0d want %0d", bus.done_steps, e); end
        ack_done();
    endtask

    task automatic test_run0_reserved();
        bit ok;
        bit got;
        bit bad;
        logic [RW-1:0] e;
        clear_mon();
        exp_q.push_back(16'd0);
        send_cmd(OP_RUN, 16'd0, ok);
        wait_done(50, got);
        e = pop_exp();
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL t5_run0_token: got %b want 1", got); end
        checks++; if (bus.done_steps !== e) begin errors++; $display("FAIL t5_run0_steps: got %0d want %0d", bus.done_steps, e); end
        ack_done();
        send_cmd(OP_RSV, 16'd4, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t5_rsv_accept: got %b want 1", ok); end
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!bus.cmd_ready || bus.done_valid || bus.clr || bus.net_step) bad = 1'b1;
            cycle();
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL t5_rsv_quiet: got activity=%b want 0", bad); end
        checks++; if (step_cnt !== 0 || clr_cnt !== 0) begin errors++; $display("FAIL t5_no_pulses: got steps=%0d clr=%0d want 0", step_cnt, clr_cnt); end
    endtask

`ifdef NET_RUN_ABORT_EN
    task automatic test_abort();
        bit ok;
        bit got;
        int k;
        logic [RW-1:0] e;
        // Abort while step 4 is in flight
        clear_mon();
        exp_q.push_back(16'd4);
        send_cmd(OP_RUN, 16'd10, ok);
        k = 0;
        for (int i = 0; i < 200 && k < 4; i++) begin
            cycle();
            if (bus.net_step) k++;
        end
        bus.abort = 1'b1;
        cycle();
        bus.abort = 1'b0;
        wait_done(100, got);
        e = pop_exp();
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL t6a_token: got %b want 1", got); end
        checks++; if (bus.done_steps !== e) begin errors++; $display("FAIL t6a_done_steps: got %0d want %0d", bus.done_steps, e); end
        checks++; if (step_cnt !== 4) begin errors++; $display("FAIL t6a_pulses: got %0d want 4", step_cnt); end
        ack_done();
        // Abort while waiting to issue step 7
        clear_mon();
        exp_q.push_back(16'd6);
        send_cmd(OP_RUN, 16'd10, ok);
        k = 0;
        for (int i = 0; i < 200 && k < 6; i++) begin
            cycle();
            if (bus.net_step) k++;
        end
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (cap_at_edge) break;
        end
        bus.abort = 1'b1;
        cycle();
        bus.abort = 1'b0;
        wait_done(100, got);
        e = pop_exp();
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL t6b_token: got %b want 1", got); end
        checks++; if (bus.done_steps !== e) begin errors++; $display("FAIL t6b_done_steps: got %0d want %0d", bus.done_steps, e); end
        checks++; if (step_cnt !== 6) begin errors++; $display("FAIL t6b_pulses: got %0d want 6", step_cnt); end
        ack_done();
    endtask
`endif

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
        bus.cmd_arg    = '0;
        bus.net_ready  = 1'b1;
        bus.done_ready = 1'b0;
`ifdef NET_RUN_ABORT_EN
        bus.abort      = 1'b0;
`endif
        test_reset();
        test_run3();
        test_stall();
        test_clr_sync();
        test_run0_reserved();
`ifdef NET_RUN_ABORT_EN
        test_abort();
`endif
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL step_clr_overlap: got %0d want 0", both_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
